acia_fifo: RTL and testbench

Parametrised serial ACIA for the 6502 system: a CPU-bus-attached UART with independent RX and TX FIFOs, configurable bit divisor, data width and FIFO depth, plus a maskable interrupt. It replaces the fixed single-byte serial port on the CPU data bus and drives the board RX/TX pins directly.

---
 rtl/acia_fifo.sv | 221 ++++++++++++++++++++++
 tb/tb_acia_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/acia_fifo.sv
// acia_fifo: 6502-bus UART with independent RX/TX FIFOs, sticky error flags and a maskable irq.
// Define ACIA_LOOPBACK_EN to build the internal tx->rx loopback selected by control bit7.
module acia_fifo #(
    parameter int DIV        = 35,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cs,
    input  logic       i_we,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout,
    output logic       o_irq,
    input  logic       i_rx,
    output logic       o_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]   DIV_M1   = 16'(DIV - 1);
    localparam logic [15:0]   HALF_M1  = 16'(DIV / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t               r_tx_state, r_rx_state;
    logic [15:0]          r_tx_cnt, r_rx_cnt;
    logic [2:0]           r_tx_bit, r_rx_bit;
    logic [DATA_BITS-1:0] r_tx_shift, r_rx_shift;
    logic                 r_tx, r_rx_s1, r_rx_s2, r_rx_d;
    logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
    logic [CW-1:0]        r_rxf_cnt, r_txf_cnt;
    logic                 r_ie_rx, r_ie_tx, r_rxovr, r_ferr, r_txovr;

    logic w_rd, w_wr, w_stat_rd, w_rx_line, w_lpbk_rd;
    logic w_rx_nempty, w_rx_full, w_tx_nempty, w_tx_full, w_tx_idle;
    logic w_rx_pop, w_rx_push_req, w_rx_push, w_ferr_set;
    logic w_tx_pop, w_tx_push_req, w_tx_push;
    logic [7:0] w_status, w_ctrl;

`ifdef ACIA_LOOPBACK_EN
    logic r_lpbk;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                       r_lpbk <= 1'b0;
        else if (w_wr && i_addr == 2'd2)    r_lpbk <= i_din[7];
    end
    assign w_rx_line = r_lpbk ? r_tx : r_rx_s2;
    assign o_tx      = r_tx | r_lpbk;
    assign w_lpbk_rd = r_lpbk;
`else
    assign w_rx_line = r_rx_s2;
    assign o_tx      = r_tx;
    assign w_lpbk_rd = 1'b0;
`endif

    assign w_rd        = i_cs & ~i_we;
    assign w_wr        = i_cs & i_we;
    assign w_stat_rd   = w_rd && (i_addr == 2'd1);
    assign w_rx_nempty = (r_rxf_cnt != '0);
    assign w_rx_full   = (r_rxf_cnt == FULL_CNT);
    assign w_tx_nempty = (r_txf_cnt != '0);
    assign w_tx_full   = (r_txf_cnt == FULL_CNT);
    assign w_tx_idle   = ~w_tx_nempty && (r_tx_state == S_IDLE);

    // A pop on the same edge frees a slot for a push into a full FIFO.
    assign w_rx_pop      = w_rd && (i_addr == 2'd0) && w_rx_nempty;
    assign w_rx_push_req = (r_rx_state == S_STOP) && (r_rx_cnt == '0) && w_rx_line;
    assign w_ferr_set    = (r_rx_state == S_STOP) && (r_rx_cnt == '0) && !w_rx_line;
    assign w_rx_push     = w_rx_push_req && (!w_rx_full || w_rx_pop);
    assign w_tx_pop      = w_tx_nempty && ((r_tx_state == S_IDLE) ||
                           ((r_tx_state == S_STOP) && (r_tx_cnt == '0)));
    assign w_tx_push_req = w_wr && (i_addr == 2'd0);
    assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);

    assign w_status = {o_irq, 1'b0, w_tx_idle, r_txovr, r_ferr, r_rxovr, ~w_tx_full, w_rx_nempty};
    assign w_ctrl   = {w_lpbk_rd, 5'b0, r_ie_tx, r_ie_rx};

    always_ff @(posedge i_clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= i_din[DATA_BITS-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_wp <= '0; r_rx_rp <= '0; r_rxf_cnt <= '0;
            r_tx_wp <= '0; r_tx_rp <= '0; r_txf_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
            r_rxf_cnt <= r_rxf_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
            r_txf_cnt <= r_txf_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dout  <= 8'h00;
            o_irq   <= 1'b0;
            r_ie_rx <= 1'b0;
            r_ie_tx <= 1'b0;
            r_rxovr <= 1'b0;
            r_ferr  <= 1'b0;
            r_txovr <= 1'b0;
        end else begin
            o_irq   <= (r_ie_rx & w_rx_nempty) | (r_ie_tx & ~w_tx_nempty);
            r_rxovr <= (w_rx_push_req & ~w_rx_push) | (r_rxovr & ~w_stat_rd);
            r_ferr  <= w_ferr_set | (r_ferr & ~w_stat_rd);
            r_txovr <= (w_tx_push_req & ~w_tx_push) | (r_txovr & ~w_stat_rd);
            if (w_wr && i_addr == 2'd2) begin
                r_ie_rx <= i_din[0];
                r_ie_tx <= i_din[1];
            end
            if (w_rd) begin
                unique case (i_addr)
                    2'd0:    o_dout <= w_rx_nempty ? 8'(r_rx_mem[r_rx_rp]) : 8'h00;
                    2'd1:    o_dout <= w_status;
                    2'd2:    o_dout <= w_ctrl;
                    default: o_dout <= 8'h00;
                endcase
            end
        end
    end

    // r_tx follows the state one edge late, so the start bit appears two edges after the write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            unique case (r_tx_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_tx_nempty) begin
                        r_tx_shift <= r_tx_mem[r_tx_rp];
                        r_tx_cnt   <= DIV_M1;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (r_tx_cnt == '0) begin
                        r_tx_cnt   <= DIV_M1;
                        r_tx_bit   <= '0;
                        r_tx_state <= S_DATA;
                    end else r_tx_cnt <= r_tx_cnt - 16'd1;
                end
                S_DATA: begin
                    r_tx <= r_tx_shift[0];
                    if (r_tx_cnt == '0) begin
                        r_tx_cnt   <= DIV_M1;
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        if (r_tx_bit == LAST_BIT) r_tx_state <= S_STOP;
                    end else r_tx_cnt <= r_tx_cnt - 16'd1;
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (r_tx_cnt == '0) begin
                        if (w_tx_nempty) begin
                            r_tx_shift <= r_tx_mem[r_tx_rp];
                            r_tx_cnt   <= DIV_M1;
                            r_tx_state <= S_START;
                        end else r_tx_state <= S_IDLE;
                    end else r_tx_cnt <= r_tx_cnt - 16'd1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= w_rx_line;
            unique case (r_rx_state)
                S_IDLE: begin
                    if (r_rx_d && !w_rx_line) begin
                        r_rx_cnt   <= HALF_M1;
                        r_rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_cnt   <= DIV_M1;
                        r_rx_bit   <= '0;
                        r_rx_state <= w_rx_line ? S_IDLE : S_DATA;
                    end else r_rx_cnt <= r_rx_cnt - 16'd1;
                end
                S_DATA: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_cnt   <= DIV_M1;
                        r_rx_shift <= {w_rx_line, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == LAST_BIT) r_rx_state <= S_STOP;
                    end else r_rx_cnt <= r_rx_cnt - 16'd1;
                end
                S_STOP: begin
                    if (r_rx_cnt == '0) r_rx_state <= S_IDLE;
                    else                r_rx_cnt   <= r_rx_cnt - 16'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_acia_fifo.sv
// Directed bench for acia_fifo: register map, TX/RX framing, FIFO overrun, FERR, irq, reset.
// Loopback checks are compiled only when ACIA_LOOPBACK_EN is defined.
module tb_acia_fifo;
    localparam int DIV = 35;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0, we = 1'b0, rx = 1'b1;
    logic [1:0] addr = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       irq, tx;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    acia_fifo #(.DIV(DIV), .DATA_BITS(8), .FIFO_DEPTH(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs), .i_we(we), .i_addr(addr),
        .i_din(din), .o_dout(dout), .o_irq(irq), .i_rx(rx), .o_tx(tx)
    );

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk); cs = 1'b0; we = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk); cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk); cs = 1'b0; d = dout;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        @(negedge clk); rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0; rx = 1'b1;
        #23;
        n_vec++; if (tx !== 1'b1)   begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_vec++; if (irq !== 1'b0)  begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout); end
        @(negedge clk); rst_n = 1'b1;
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'h22) begin n_err++; $display("FAIL reset_status: got %h want 22", d); end
        cpu_read(2'd0, d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_empty_read: got %h want 00", d); end
    endtask

    task automatic test_tx_frame();
        logic [7:0] d;
        logic [9:0] bits;
        bits = {1'b1, 8'h55, 1'b0};
        cpu_write(2'd0, 8'h55);
        @(negedge clk);
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL tx_one_edge: got %b want 1", tx); end
        @(negedge clk);
        n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL tx_start_two_edges: got %b want 0", tx); end
        repeat (DIV / 2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (tx !== bits[k]) begin n_err++; $display("FAIL tx_bit%0d: got %b want %b", k, tx, bits[k]); end
            repeat (DIV) @(negedge clk);
        end
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'h22) begin n_err++; $display("FAIL tx_idle_status: got %h want 22", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        cpu_write(2'd0, 8'hFF);
        cpu_write(2'd0, 8'h00);
        repeat (349) @(negedge clk);
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL b2b_stop_end: got %b want 1", tx); end
        @(negedge clk);
        n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL b2b_next_start: got %b want 0", tx); end
        repeat (DIV / 2 + 4 * DIV) @(negedge clk);
        n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL b2b_data_bit: got %b want 0", tx); end
        repeat (6 * DIV) @(negedge clk);
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL b2b_stop: got %b want 1", tx); end
        repeat (DIV) @(negedge clk);
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'h22) begin n_err++; $display("FAIL b2b_idle_status: got %h want 22", d); end
    endtask

    task automatic test_rx_irq();
        logic [7:0] d;
        cpu_write(2'd2, 8'h01);
        @(negedge clk);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rx_irq_idle: got %b want 0", irq); end
        rx_send(8'hA3, 1'b1);
        @(negedge clk);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL rx_irq_rise: got %b want 1", irq); end
        cpu_read(2'd0, d);
        n_vec++; if (d !== 8'hA3) begin n_err++; $display("FAIL rx_data: got %h want a3", d); end
        @(negedge clk);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rx_irq_fall: got %b want 0", irq); end
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'h22) begin n_err++; $display("FAIL rx_status_after: got %h want 22", d); end
        cpu_write(2'd2, 8'h00);
    endtask

    task automatic test_rx_overrun();
        logic [7:0] d;
        logic [7:0] pat [17];
        for (int i = 0; i < 17; i++) pat[i] = 8'(i * 37 + 5);
        for (int i = 0; i < 17; i++) rx_send(pat[i], 1'b1);
        repeat (4) @(negedge clk);
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'h27) begin n_err++; $display("FAIL ovr_status: got %h want 27", d); end
        for (int i = 0; i < 16; i++) begin
            cpu_read(2'd0, d);
            n_vec++;
            if (d !== pat[i]) begin n_err++; $display("FAIL ovr_read%0d: got %h want %h", i, d, pat[i]); end
        end
        cpu_read(2'd0, d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL ovr_17th_dropped: got %h want 00", d); end
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'h22) begin n_err++; $display("FAIL ovr_cleared: got %h want 22", d); end
    endtask

    task automatic test_ferr_glitch();
        logic [7:0] d;
        rx_send(8'h5A, 1'b0);
        repeat (DIV) @(negedge clk);
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'h2A) begin n_err++; $display("FAIL ferr_status: got %h want 2a", d); end
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'h22) begin n_err++; $display("FAIL ferr_cleared: got %h want 22", d); end
        @(negedge clk); rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (12 * DIV) @(negedge clk);
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'h22) begin n_err++; $display("FAIL glitch_status: got %h want 22", d); end
    endtask

    task automatic test_ctrl_regs();
        logic [7:0] d;
        logic [7:0] exp_ctrl;
`ifdef ACIA_LOOPBACK_EN
        exp_ctrl = 8'h83;
`else
        exp_ctrl = 8'h03;
`endif
        cpu_write(2'd2, 8'hFF);
        cpu_read(2'd2, d);
        n_vec++; if (d !== exp_ctrl) begin n_err++; $display("FAIL ctrl_read: got %h want %h", d, exp_ctrl); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL tx_irq: got %b want 1", irq); end
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'hA2) begin n_err++; $display("FAIL status_irq_bit: got %h want a2", d); end
        cpu_write(2'd3, 8'hFF);
        cpu_read(2'd3, d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL addr3_read: got %h want 00", d); end
        cpu_write(2'd2, 8'h00);
        @(negedge clk);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_masked: got %b want 0", irq); end
    endtask

`ifdef ACIA_LOOPBACK_EN
    task automatic test_loopback();
        logic [7:0] d;
        logic       saw_low;
        saw_low = 1'b0;
        cpu_write(2'd2, 8'h80);
        cpu_write(2'd0, 8'h3C);
        for (int i = 0; i < 420; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        n_vec++; if (saw_low !== 1'b0) begin n_err++; $display("FAIL lpbk_tx_pin: got low want held 1"); end
        cpu_read(2'd0, d);
        n_vec++; if (d !== 8'h3C) begin n_err++; $display("FAIL lpbk_data: got %h want 3c", d); end
        cpu_write(2'd2, 8'h00);
    endtask
`endif

    task automatic test_txovr_midframe_reset();
        logic [7:0] d;
        for (int i = 0; i < 18; i++) cpu_write(2'd0, 8'h00);
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'h10) begin n_err++; $display("FAIL txovr_status: got %h want 10", d); end
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL txovr_cleared: got %h want 00", d); end
        n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL midframe_tx_low: got %b want 0", tx); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_abort_tx: got %b want 1", tx); end
        @(negedge clk); rst_n = 1'b1;
        cpu_read(2'd1, d);
        n_vec++; if (d !== 8'h22) begin n_err++; $display("FAIL reset_flush: got %h want 22", d); end
        repeat (3 * DIV) @(negedge clk);
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_no_resume: got %b want 1", tx); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_rx_irq();
        test_rx_overrun();
        test_ferr_glitch();
        test_ctrl_regs();
`ifdef ACIA_LOOPBACK_EN
        test_loopback();
`endif
        test_txovr_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
